// File: rtl/lb_event_stats.sv
// Local-bus event statistics block: four saturating event counters on synchronized event lines.
// Define LB_EVT_TIMESTAMP_EN to include the free-running TSTAMP counter; otherwise TSTAMP reads as 0.
module lb_event_stats #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
    input  logic        clk_lb,
    input  logic        reset_l,
    input  logic        lb_wr,
    input  logic        lb_rd,
    input  logic [31:0] lb_addr,
    input  logic [31:0] lb_wr_d,
    output logic [31:0] lb_rd_d,
    output logic        lb_rd_rdy,
    input  logic [31:0] events_din
);

    localparam int NUM_CNT = 4;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic evt_qualify(input logic cur, input logic prev, input logic [1:0] mode);
        logic q;
        case (mode)
            2'd0:    q = cur & ~prev;
            2'd1:    q = ~cur & prev;
            2'd2:    q = cur ^ prev;
            default: q = cur;
        endcase
        return q;
    endfunction

    logic [31:0] evt_p0, evt_p1, evt_p2;
    logic        ctrl_en_q;
    logic [31:0] sel_q;
    logic [31:0] cnt_q [NUM_CNT];
    logic [31:0] tstamp;

    logic        addr_hit;
    logic [2:0]  reg_sel;
    logic        wr_ctrl, wr_sel, clr_req;
    logic        rd_vld_p0;
    logic [31:0] rd_mux;
    logic [NUM_CNT-1:0] evt_hit;
    logic        unused_addr_lsb;

    assign addr_hit        = (lb_addr[31:5] == BASE_ADDR[31:5]);
    assign reg_sel         = lb_addr[4:2];
    assign unused_addr_lsb = ^lb_addr[1:0];
    assign wr_ctrl         = lb_wr & addr_hit & (reg_sel == 3'd0);
    assign wr_sel          = lb_wr & addr_hit & (reg_sel == 3'd1);
    assign clr_req         = wr_ctrl & lb_wr_d[1];
    assign rd_vld_p0       = lb_rd & addr_hit;

    // Stage p0/p1: two-flop synchronizer; p2: per-channel history for edge detection
    always_ff @(posedge clk_lb) begin
        if (!reset_l) begin
            evt_p0 <= '0;
            evt_p1 <= '0;
            evt_p2 <= '0;
        end else begin
            evt_p0 <= events_din;
            evt_p1 <= evt_p0;
            evt_p2 <= evt_p1;
        end
    end

    always_ff @(posedge clk_lb) begin
        if (!reset_l) begin
            ctrl_en_q <= 1'b0;
            sel_q     <= '0;
        end else begin
            if (wr_ctrl) ctrl_en_q <= lb_wr_d[0];
            if (wr_sel)  sel_q     <= lb_wr_d;
        end
    end

    // History covers every channel, so retargeting SEL never fabricates an edge
    always_comb begin
        logic [4:0] ch;
        logic [1:0] mode;
        ch      = '0;
        mode    = '0;
        evt_hit = '0;
        for (int n = 0; n < NUM_CNT; n++) begin
            ch         = sel_q[8*n +: 5];
            mode       = sel_q[8*n+5 +: 2];
            evt_hit[n] = ctrl_en_q & evt_qualify(evt_p1[ch], evt_p2[ch], mode);
        end
    end

    always_ff @(posedge clk_lb) begin
        if (!reset_l) begin
            for (int n = 0; n < NUM_CNT; n++) cnt_q[n] <= '0;
        end else begin
            for (int n = 0; n < NUM_CNT; n++) begin
                if (clr_req)         cnt_q[n] <= '0;
                else if (evt_hit[n]) cnt_q[n] <= sat_inc(cnt_q[n]);
            end
        end
    end

`ifdef LB_EVT_TIMESTAMP_EN
    logic [31:0] tstamp_q;

    always_ff @(posedge clk_lb) begin
        if (!reset_l)       tstamp_q <= '0;
        else if (clr_req)   tstamp_q <= '0;
        else if (ctrl_en_q) tstamp_q <= tstamp_q + 32'd1;
    end

    assign tstamp = tstamp_q;
`else
    assign tstamp = '0;
`endif

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            3'd0:    rd_mux = {31'd0, ctrl_en_q};
            3'd1:    rd_mux = sel_q;
            3'd2:    rd_mux = cnt_q[0];
            3'd3:    rd_mux = cnt_q[1];
            3'd4:    rd_mux = cnt_q[2];
            3'd5:    rd_mux = cnt_q[3];
            3'd6:    rd_mux = tstamp;
            default: rd_mux = evt_p1;
        endcase
    end

    // Stage p1: registered read response; data forced to 0 when not ready for OR-combining
    always_ff @(posedge clk_lb) begin
        if (!reset_l) begin
            lb_rd_rdy <= 1'b0;
            lb_rd_d   <= '0;
        end else begin
            lb_rd_rdy <= rd_vld_p0;
            lb_rd_d   <= rd_vld_p0 ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_lb_event_stats.sv
// Self-checking bench for lb_event_stats: directed scenarios plus randomized bus/event traffic
// compared every cycle against a sample-history reference model.
module tb_lb_event_stats;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk_lb = 1'b0;
    logic        reset_l, lb_wr, lb_rd, lb_rd_rdy;
    logic [31:0] lb_addr, lb_wr_d, lb_rd_d, events_din;

    int n_vec = 0;
    int n_err = 0;

    lb_event_stats #(.BASE_ADDR(BASE)) dut (
        .clk_lb     (clk_lb),
        .reset_l    (reset_l),
        .lb_wr      (lb_wr),
        .lb_rd      (lb_rd),
        .lb_addr    (lb_addr),
        .lb_wr_d    (lb_wr_d),
        .lb_rd_d    (lb_rd_d),
        .lb_rd_rdy  (lb_rd_rdy),
        .events_din (events_din)
    );

    always #5 clk_lb = ~clk_lb;

    // Reference state: register contents plus the raw input samples of the last three edges
    logic        m_en, m_rdy;
    logic [31:0] m_sel, m_ts, m_rdd;
    logic [31:0] m_cnt [4];
    logic [31:0] m_hist [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit qual(input bit cur, input bit prev, input int mode);
        if (mode == 0) return cur && !prev;
        if (mode == 1) return !cur && prev;
        if (mode == 2) return cur != prev;
        return cur;
    endfunction

    task automatic model_edge();
        logic [31:0] rv;
        bit hit, clr;
        int off;
        if (!reset_l) begin
            m_en = 0; m_sel = 0; m_ts = 0; m_rdy = 0; m_rdd = 0;
            for (int n = 0; n < 4; n++) m_cnt[n] = 0;
            m_hist = '{32'd0, 32'd0, 32'd0};
            return;
        end
        hit = (lb_addr[31:5] == BASE[31:5]);
        off = int'(lb_addr[4:2]);
        if (off == 0)      rv = {31'd0, m_en};
        else if (off == 1) rv = m_sel;
        else if (off <= 5) rv = m_cnt[off-2];
        else if (off == 6) begin
`ifdef LB_EVT_TIMESTAMP_EN
            rv = m_ts;
`else
            rv = 32'd0;
`endif
        end
        else rv = m_hist[1];
        m_rdy = lb_rd && hit;
        m_rdd = m_rdy ? rv : 32'd0;
        clr = lb_wr && hit && off == 0 && lb_wr_d[1];
        // Input sampled two edges ago versus three edges ago decides the event
        for (int n = 0; n < 4; n++) begin
            int ch;
            int md;
            ch = int'(m_sel[8*n +: 5]);
            md = int'(m_sel[8*n+5 +: 2]);
            if (clr) m_cnt[n] = 0;
            else if (m_en && qual(m_hist[1][ch], m_hist[2][ch], md) && m_cnt[n] != 32'hFFFF_FFFF)
                m_cnt[n] = m_cnt[n] + 1;
        end
        if (clr) m_ts = 0;
        else if (m_en) m_ts = m_ts + 1;
        if (lb_wr && hit && off == 0) m_en = lb_wr_d[0];
        if (lb_wr && hit && off == 1) m_sel = lb_wr_d;
        m_hist.push_front(events_din);
        void'(m_hist.pop_back());
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk_lb);
        #1;
        check("rdy", 32'(lb_rd_rdy), 32'(m_rdy));
        check("rd_d", lb_rd_d, m_rdd);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        lb_wr = 1; lb_addr = a; lb_wr_d = d;
        tick();
        lb_wr = 0;
    endtask

    task automatic bus_rd(input logic [31:0] a);
        lb_rd = 1; lb_addr = a;
        tick();
        lb_rd = 0;
    endtask

    task automatic pulse_bit(input int b, input int times);
        for (int i = 0; i < times; i++) begin
            events_din[b] = 1'b1; ticks(2);
            events_din[b] = 1'b0; ticks(2);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, wd;
        int r, off;
        reset_l = 0; lb_wr = 0; lb_rd = 0; lb_addr = 0; lb_wr_d = 0; events_din = 0;
        m_hist = '{32'd0, 32'd0, 32'd0};

        // Read pending through reset must never produce a ready pulse
        lb_rd = 1; lb_addr = BASE + 32'h1C;
        ticks(3);
        lb_rd = 0; reset_l = 1;
        ticks(2);
        check("rst_rdy_idle", 32'(lb_rd_rdy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            bus_rd(BASE + 32'(4*i));
            check("rst_reg_rdy", 32'(lb_rd_rdy), 32'd1);
            check("rst_reg_val", lb_rd_d, 32'd0);
        end

        // LIVE readback
        events_din = 32'hA5A5_0003;
        ticks(3);
        bus_rd(BASE + 32'h1C);
        check("live_rdy", 32'(lb_rd_rdy), 32'd1);
        check("live_val", lb_rd_d, 32'hA5A5_0003);

        // Five rising edges on ch0, all counters selecting ch0 rise
        events_din = 0;
        bus_wr(BASE + 32'h04, 32'h0);
        bus_wr(BASE + 32'h00, 32'h2);
        ticks(3);
        bus_wr(BASE + 32'h00, 32'h1);
        pulse_bit(0, 5);
        ticks(3);
        for (int n = 0; n < 4; n++) begin
            bus_rd(BASE + 32'h08 + 32'(4*n));
            check("cnt_rise5", lb_rd_d, 32'd5);
        end

        // Level mode on ch3 for counter 1
        bus_wr(BASE + 32'h04, 32'h0000_6300);
        bus_wr(BASE + 32'h00, 32'h3);
        events_din[3] = 1'b1; ticks(10);
        events_din[3] = 1'b0; ticks(3);
        bus_rd(BASE + 32'h0C);
        check("cnt1_level10", lb_rd_d, 32'd10);

        // Saturation from a preloaded near-full counter
        bus_wr(BASE + 32'h00, 32'h0);
        bus_wr(BASE + 32'h04, 32'h0);
        tick();
        dut.cnt_q[0] = 32'hFFFF_FFFE;
        m_cnt[0]     = 32'hFFFF_FFFE;
        bus_wr(BASE + 32'h00, 32'h1);
        pulse_bit(0, 4);
        ticks(3);
        bus_rd(BASE + 32'h08);
        check("cnt0_sat", lb_rd_d, 32'hFFFF_FFFF);
        bus_rd(BASE + 32'h0C);
        check("cnt1_after_sat", lb_rd_d, 32'd14);

        // Clear coincident with a qualified rising edge: clear wins, enable kept
        events_din[0] = 1'b1;
        ticks(2);
        bus_wr(BASE + 32'h00, 32'h3);
        tick();
        bus_rd(BASE + 32'h00);
        check("ctrl_en_kept", lb_rd_d, 32'h1);
        for (int n = 0; n < 4; n++) begin
            bus_rd(BASE + 32'h08 + 32'(4*n));
            check("cnt_clr_wins", lb_rd_d, 32'd0);
        end

        // Out-of-range reads and the TSTAMP slot
        bus_rd(BASE + 32'h20);
        check("oor_rdy", 32'(lb_rd_rdy), 32'd0);
        check("oor_data", lb_rd_d, 32'd0);
        bus_rd(BASE - 32'h4);
        check("below_rdy", 32'(lb_rd_rdy), 32'd0);
        bus_rd(BASE + 32'h18);
        check("ts_rdy", 32'(lb_rd_rdy), 32'd1);
`ifndef LB_EVT_TIMESTAMP_EN
        check("ts_zero", lb_rd_d, 32'd0);
`endif

        // Simultaneous read and write returns the old value
        lb_rd = 1; lb_wr = 1; lb_addr = BASE + 32'h04; lb_wr_d = 32'h1234_5678;
        tick();
        lb_rd = 0; lb_wr = 0;
        check("rdwr_old", lb_rd_d, 32'h0);
        bus_rd(BASE + 32'h04);
        check("sel_readback", lb_rd_d, 32'h1234_5678);

        // Writes to read-only and undecoded addresses are ignored
        bus_wr(BASE + 32'h08, 32'hDEAD_BEEF);
        bus_wr(BASE + 32'h20, 32'h0);
        bus_rd(BASE + 32'h08);
        check("ro_ignored", lb_rd_d, 32'd0);
        bus_rd(BASE + 32'h00);
        check("undec_ignored", lb_rd_d, 32'h1);

        // Back-to-back reads
        lb_rd = 1; lb_addr = BASE + 32'h00; tick();
        check("b2b_first", lb_rd_d, 32'h1);
        lb_addr = BASE + 32'h04; tick();
        check("b2b_second", lb_rd_d, 32'h1234_5678);
        lb_rd = 0; tick();
        check("b2b_end_rdy", 32'(lb_rd_rdy), 32'd0);

        // Retargeting SEL onto a channel that is already high must not count
        bus_wr(BASE + 32'h04, 32'h0);
        events_din[5] = 1'b1;
        ticks(4);
        bus_wr(BASE + 32'h00, 32'h3);
        bus_wr(BASE + 32'h04, 32'h0505_0505);
        ticks(3);
        bus_rd(BASE + 32'h08);
        check("sel_no_spurious", lb_rd_d, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            reset_l = !(i >= 1200 && i < 1202);
            events_din = events_din ^ ($urandom & $urandom & $urandom & $urandom);
            lb_rd = 0; lb_wr = 0;
            r   = int'($urandom_range(0, 15));
            off = int'($urandom_range(0, 7));
            a   = BASE + 32'(4*off) + 32'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0: a = $urandom;
                1: a = BASE ^ (32'h20 << $urandom_range(0, 26));
                default: ;
            endcase
            if (off == 0) begin
                wd    = 32'h0;
                wd[0] = ($urandom_range(0, 3) != 0);
                wd[1] = ($urandom_range(0, 31) == 0);
            end else begin
                wd = $urandom;
            end
            if (i >= 1198 && i < 1202) r = 0;
            lb_addr = a;
            lb_wr_d = wd;
            lb_rd   = (r < 6);
            lb_wr   = (r >= 4 && r < 8);
            tick();
        end
        lb_rd = 0; lb_wr = 0;
        for (int i = 0; i < 8; i++) bus_rd(BASE + 32'(4*i));
        ticks(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
